sample_averager: RTL and testbench

Sliding-window mean filter between the ADC interface's 16-bit raw sample and the data processor. It keeps the last 2^LOG2_N accepted samples in a circular buffer with a running sum. After the window first fills, it outputs the truncated mean with a one-cycle valid strobe for every new sample. This steadies the voltmeter reading before scaling and display.

---
 rtl/sample_averager.sv | 152 +++++++++++++++
 tb/tb_sample_averager.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/sample_averager.sv
// -----------------------------------------------------------------------------
// sample_averager
//
// Sliding-window mean filter placed between the ADC interface and the data
// processor. It keeps the last N = 2**LOG2_N accepted samples in a circular
// buffer together with a running sum. Once the window has filled, every
// accepted sample produces a truncated mean on avg_o one clock later, flagged
// by a single-cycle avg_valid_o strobe.
//
// Optional feature macro: SAMPLE_AVERAGER_FLUSH_EN
//   When defined, the input flush_i is added. It synchronously empties the
//   window (back to FILL) and leaves avg_o holding its last value.
//
// Parameters
//   WIDTH   sample width in bits (unsigned)
//   LOG2_N  log2 of the window depth, 1..6
//
// Ports
//   clk_i           system clock
//   reset           asynchronous active-high reset, clears all state
//   flush_i         (SAMPLE_AVERAGER_FLUSH_EN only) synchronous window flush
//   sample_i        raw ADC sample
//   sample_valid_i  sample_i is accepted on a rising edge where this is high
//   avg_o           registered window mean, floor(sum / N)
//   avg_valid_o     one-cycle pulse in the cycle avg_o updates
//   full_o          high once N samples have been accepted since reset/flush
// -----------------------------------------------------------------------------
module sample_averager #(
    parameter int WIDTH  = 16,
    parameter int LOG2_N = 4
) (
    input  logic             clk_i,
    input  logic             reset,
`ifdef SAMPLE_AVERAGER_FLUSH_EN
    input  logic             flush_i,
`endif
    input  logic [WIDTH-1:0] sample_i,
    input  logic             sample_valid_i,
    output logic [WIDTH-1:0] avg_o,
    output logic             avg_valid_o,
    output logic             full_o
);

    localparam int N     = 1 << LOG2_N;
    localparam int SUM_W = WIDTH + LOG2_N;

    // Fill count that, once one more sample is accepted, completes the window.
    localparam logic [LOG2_N:0] LAST_FILL_CNT = (LOG2_N + 1)'(N - 1);

    typedef enum logic {
        ST_FILL = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t            state_reg, state_next;
    logic [LOG2_N-1:0] wp_reg, wp_next;
    logic [LOG2_N:0]   cnt_reg, cnt_next;
    logic [SUM_W-1:0]  sum_reg, sum_next;
    logic              pending_reg, pending_next;
    logic [WIDTH-1:0]  avg_reg;
    logic              avg_valid_reg;

    logic [WIDTH-1:0]  buf_mem [N];

    logic              flush;
    logic              accept;
    logic [WIDTH-1:0]  oldest;

`ifdef SAMPLE_AVERAGER_FLUSH_EN
    assign flush = flush_i;
`else
    assign flush = 1'b0;
`endif

    // A flush discards any sample presented in the same cycle.
    assign accept = sample_valid_i & ~flush;

    // While filling, the slot at wp has never been written since reset/flush,
    // so nothing is evicted; force zero rather than trusting stale contents.
    assign oldest = (state_reg == ST_RUN) ? buf_mem[wp_reg] : '0;

    // ---------------------------------------------------------------- state reg
    always_ff @(posedge clk_i or posedge reset) begin
        if (reset) begin
            state_reg     <= ST_FILL;
            wp_reg        <= '0;
            cnt_reg       <= '0;
            sum_reg       <= '0;
            pending_reg   <= 1'b0;
            avg_reg       <= '0;
            avg_valid_reg <= 1'b0;
        end else begin
            state_reg   <= state_next;
            wp_reg      <= wp_next;
            cnt_reg     <= cnt_next;
            sum_reg     <= sum_next;
            pending_reg <= pending_next;
            // sum_reg already includes the acceptance from the previous edge,
            // which gives the one-clock acceptance-to-output latency.
            avg_valid_reg <= pending_reg & ~flush;
            if (pending_reg && !flush) begin
                avg_reg <= sum_reg[SUM_W-1:LOG2_N];
            end
        end
    end

    // Sample storage needs no reset: every slot is written before it is read.
    always_ff @(posedge clk_i) begin
        if (accept) begin
            buf_mem[wp_reg] <= sample_i;
        end
    end

    // ----------------------------------------------------------- next state
    always_comb begin
        state_next = state_reg;
        if (flush) begin
            state_next = ST_FILL;
        end else if (accept && (state_reg == ST_FILL) && (cnt_reg == LAST_FILL_CNT)) begin
            state_next = ST_RUN;
        end
    end

    // ------------------------------------------------------ datapath next
    always_comb begin
        wp_next      = wp_reg;
        cnt_next     = cnt_reg;
        sum_next     = sum_reg;
        pending_next = 1'b0;
        if (flush) begin
            wp_next  = '0;
            cnt_next = '0;
            sum_next = '0;
        end else if (accept) begin
            // Sum never exceeds N * (2**WIDTH - 1), so SUM_W bits suffice.
            sum_next = sum_reg + SUM_W'(sample_i) - SUM_W'(oldest);
            wp_next  = wp_reg + 1'b1;   // wraps mod N by width
            if (state_reg == ST_FILL) begin
                cnt_next = cnt_reg + 1'b1;
            end
            pending_next = (state_next == ST_RUN);
        end
    end

    // ------------------------------------------------------------- outputs
    always_comb begin
        full_o      = (state_reg == ST_RUN);
        avg_o       = avg_reg;
        avg_valid_o = avg_valid_reg;
    end

endmodule

// File: tb/tb_sample_averager.sv
module tb_sample_averager;

    localparam int W = 16;
    localparam int L = 2;
    localparam int N = 4;

    logic         clk            = 1'b0;
    logic         reset          = 1'b1;
    logic         flush_i        = 1'b0;
    logic [W-1:0] sample_i       = '0;
    logic         sample_valid_i = 1'b0;
    logic [W-1:0] avg_o;
    logic         avg_valid_o;
    logic         full_o;

    sample_averager #(
        .WIDTH (W),
        .LOG2_N(L)
    ) dut (
        .clk_i         (clk),
        .reset         (reset),
`ifdef SAMPLE_AVERAGER_FLUSH_EN
        .flush_i       (flush_i),
`endif
        .sample_i      (sample_i),
        .sample_valid_i(sample_valid_i),
        .avg_o         (avg_o),
        .avg_valid_o   (avg_valid_o),
        .full_o        (full_o)
    );

    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;

    // Scoreboard: expected averages queued when the sample is driven.
    int exp_q[$];
    bit due      = 1'b0;
    int last_avg = 0;

    // Reference window model.
    int win[N];
    int m_wp  = 0;
    int m_cnt = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset(input bit clear_avg);
        for (int i = 0; i < N; i++) win[i] = 0;
        m_wp  = 0;
        m_cnt = 0;
        exp_q.delete();
        due = 1'b0;
        if (clear_avg) last_avg = 0;
    endtask

    // One clock: drive at the falling edge, sample outputs 1 time unit after
    // the rising edge, then advance the model with this cycle's acceptance.
    task automatic step(input bit v, input int d, input bit f = 1'b0);
        int e;
        int s;
        @(negedge clk);
        sample_valid_i = v;
        sample_i       = d[W-1:0];
        flush_i        = f;
        @(posedge clk);
        #1;
        if (f) begin
            check("valid_on_flush", 32'(avg_valid_o), 32'd0);
            if (due) void'(exp_q.pop_front());
        end else begin
            check("avg_valid", 32'(avg_valid_o), 32'(due));
            if (due) begin
                e = exp_q.pop_front();
                if (avg_valid_o === 1'b1) begin
                    check("avg", 32'(avg_o), 32'(e));
                    last_avg = e;
                end
            end
        end
        if (avg_valid_o !== 1'b1) check("avg_hold", 32'(avg_o), 32'(last_avg));

        due = 1'b0;
        if (f) begin
            model_reset(1'b0);
        end else if (v) begin
            win[m_wp] = d;
            m_wp = (m_wp + 1) % N;
            if (m_cnt < N) m_cnt++;
            if (m_cnt == N) begin
                s = 0;
                for (int i = 0; i < N; i++) s += win[i];
                exp_q.push_back(s / N);
                due = 1'b1;
            end
        end
        check("full", 32'(full_o), 32'(m_cnt == N));
    endtask

    // Assert reset between clock edges and confirm outputs clear at once.
    task automatic async_reset(input bit valid_during);
        @(negedge clk);
        sample_valid_i = valid_during;
        sample_i       = 16'd9999;
        flush_i        = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        check("async_full", 32'(full_o), 32'd0);
        check("async_valid", 32'(avg_valid_o), 32'd0);
        check("async_avg", 32'(avg_o), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        check("reset_hold_full", 32'(full_o), 32'd0);
        @(negedge clk);
        reset          = 1'b0;
        sample_valid_i = 1'b0;
        model_reset(1'b1);
    endtask

    initial begin
        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("reset_avg", 32'(avg_o), 32'd0);
        check("reset_valid", 32'(avg_valid_o), 32'd0);
        check("reset_full", 32'(full_o), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        model_reset(1'b1);

        // Fill, first average, then eviction across the pointer wrap
        step(1, 100); step(1, 200); step(1, 300); step(1, 400);
        step(1, 500);
        step(1, 0); step(1, 0); step(1, 0); step(1, 0);
        step(0, 0);
        check("wrap_final_avg", 32'(avg_o), 32'd0);

        // Full-scale samples and truncation
        step(1, 65535); step(1, 65535); step(1, 65535); step(1, 65535);
        step(1, 2);
        step(0, 0);
        check("trunc_avg", 32'(avg_o), 32'd49151);

        // Sparse strobes: output holds, no pulse in between
        for (int k = 0; k < 3; k++) begin
            step(1, 1000 * k + 7);
            repeat (7) step(0, 0);
        end

        // Asynchronous reset while in RUN with a nonzero average
        async_reset(1'b1);
        // Reset mid-fill, then a clean window of 1000
        step(1, 5000); step(1, 6000);
        async_reset(1'b0);
        step(1, 1000); step(1, 1000); step(1, 1000); step(1, 1000);
        step(0, 0);
        check("post_reset_avg", 32'(avg_o), 32'd1000);

`ifdef SAMPLE_AVERAGER_FLUSH_EN
        // Flush in RUN: sample discarded, avg holds, window refills
        step(1, 100); step(1, 200); step(1, 300); step(1, 400);
        step(0, 0);
        step(1, 77, 1'b1);
        check("flush_avg_hold", 32'(avg_o), 32'd250);
        step(1, 8); step(1, 8); step(1, 8); step(1, 8);
        step(0, 0);
        check("flush_refill_avg", 32'(avg_o), 32'd8);
`endif

        step(0, 0);
        check("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
